// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - shared constants for the instruction memory loader
package instruction_loader_pkg;

  localparam int BYTE_LANE_W = 8;
  localparam int LANE_SEL_W  = 2;
  localparam int WORD_W      = 32;

  localparam logic [WORD_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RECEIVE = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_ERROR   = 3'd5;

endpackage

// File: rtl/instruction_loader_if.sv
// rtl/instruction_loader_if.sv - byte stream in, memory write port and status out
interface instruction_loader_if
  import instruction_loader_pkg::*;
#(
  parameter int MEMORY_WIDTH = BYTE_LANE_W,
  parameter int NB_ADDR      = 32
);

  logic                    i_start;
  logic                    i_byte_valid;
  logic [MEMORY_WIDTH-1:0] i_byte_data;
  logic                    o_byte_ready;
  logic                    o_write_enable;
  logic [NB_ADDR-1:0]      o_write_addr;
  logic [MEMORY_WIDTH-1:0] o_write_data;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_overflow;
  logic [NB_ADDR-1:0]      o_byte_count;

  // master: debug unit / byte source side; slave: the loader itself
  modport master (
    output i_start, i_byte_valid, i_byte_data,
    input  o_byte_ready, o_write_enable, o_write_addr, o_write_data,
           o_busy, o_done, o_overflow, o_byte_count
  );

  modport slave (
    input  i_start, i_byte_valid, i_byte_data,
    output o_byte_ready, o_write_enable, o_write_addr, o_write_data,
           o_busy, o_done, o_overflow, o_byte_count
  );

endinterface

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - writes a byte stream into instruction memory until an aligned HALT word
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int                    MEMORY_WIDTH     = BYTE_LANE_W,
  parameter int                    MEMORY_DEPTH     = 64,
  parameter int                    NB_ADDR          = 32,
  parameter int                    NB_INSTRUCTION   = WORD_W,
  parameter logic [NB_INSTRUCTION-1:0] HALT_INSTRUCTION = HALT_WORD
) (
  input  logic               i_clock,
  input  logic               i_reset,
  instruction_loader_if.slave bus
);

  logic [2:0]                state_q, state_d;
  logic [NB_ADDR-1:0]        addr_q, addr_d;
  logic [MEMORY_WIDTH-1:0]   byte_q, byte_d;
  logic [NB_INSTRUCTION-1:0] word_q, word_d;
  logic [LANE_SEL_W-1:0]     lane;

  assign lane = addr_q[LANE_SEL_W-1:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (bus.i_start) begin
          state_d = ST_RECEIVE;
          addr_d  = '0;
          word_d  = '0;
        end
      end
      ST_RECEIVE: begin
        if (bus.i_byte_valid) begin
          byte_d  = bus.i_byte_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // little-endian lane placement: address offset k lands in bits [8k+7:8k]
        word_d[int'(lane)*MEMORY_WIDTH +: MEMORY_WIDTH] = byte_q;
        addr_d  = addr_q + 1'b1;
        state_d = (&lane) ? ST_CHECK : ST_RECEIVE;
      end
      ST_CHECK: begin
        if (word_q == HALT_INSTRUCTION)
          state_d = ST_DONE;
        else if (addr_q == NB_ADDR'(MEMORY_DEPTH))
          state_d = ST_ERROR;
        else
          state_d = ST_RECEIVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      byte_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
    end
  end

  // every output decodes straight from registered state, so an async reset clears them at once
  assign bus.o_byte_ready   = (state_q == ST_RECEIVE);
  assign bus.o_write_enable = (state_q == ST_WRITE);
  assign bus.o_write_addr   = (state_q == ST_WRITE) ? addr_q : '0;
  assign bus.o_write_data   = (state_q == ST_WRITE) ? byte_q : '0;
  assign bus.o_busy         = (state_q == ST_RECEIVE) || (state_q == ST_WRITE) ||
                              (state_q == ST_CHECK);
  assign bus.o_done         = (state_q == ST_DONE);
  assign bus.o_overflow     = (state_q == ST_ERROR);
  assign bus.o_byte_count   = addr_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - directed bench with a cycle-timeline reference model
module tb_instruction_loader;

  localparam longint INF = 64'd1 << 40;

  logic   clk;
  logic   rst_n;
  longint cyc;
  int     n_checks;
  int     n_pass;

  instruction_loader_if #(.MEMORY_WIDTH(8), .NB_ADDR(32)) bus ();

  instruction_loader dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t wlog[$];

  // model: each output is a function of the cycle number against a few event times
  longint     m_rdy, m_wr, m_busy_from, m_busy_until, m_done, m_ovf;
  int         m_count;
  logic [31:0] m_wr_addr;
  logic [7:0]  m_wr_data;
  logic [7:0]  grp [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    m_rdy        = INF;
    m_wr         = -1;
    m_busy_from  = INF;
    m_busy_until = INF;
    m_done       = INF;
    m_ovf        = INF;
    m_count      = 0;
    m_wr_addr    = '0;
    m_wr_data    = '0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    logic        e_we, e_ready, e_busy;
    logic [31:0] e_cnt;
    logic [31:0] word;
    if (!rst_n) begin
      model_reset();
    end else begin
      e_we    = (cyc == m_wr);
      e_ready = (cyc >= m_rdy);
      e_busy  = (cyc >= m_busy_from) && (cyc < m_busy_until);
      e_cnt   = (cyc <= m_wr) ? 32'(m_count - 1) : 32'(m_count);
      chk("write_enable", 32'(bus.o_write_enable), 32'(e_we));
      chk("write_addr",   bus.o_write_addr, e_we ? m_wr_addr : 32'd0);
      chk("write_data",   32'(bus.o_write_data), e_we ? 32'(m_wr_data) : 32'd0);
      chk("byte_ready",   32'(bus.o_byte_ready), 32'(e_ready));
      chk("busy",         32'(bus.o_busy), 32'(e_busy));
      chk("done",         32'(bus.o_done), 32'(cyc >= m_done));
      chk("overflow",     32'(bus.o_overflow), 32'(cyc >= m_ovf));
      chk("byte_count",   bus.o_byte_count, e_cnt);
      if (bus.o_write_enable) wlog.push_back('{addr: bus.o_write_addr, data: bus.o_write_data});

      if (bus.i_start && !e_busy) begin
        m_count      = 0;
        m_wr         = -1;
        m_rdy        = cyc + 1;
        m_busy_from  = cyc + 1;
        m_busy_until = INF;
        m_done       = INF;
        m_ovf        = INF;
      end else if (bus.i_byte_valid && e_ready) begin
        m_wr      = cyc + 1;
        m_wr_addr = 32'(m_count);
        m_wr_data = bus.i_byte_data;
        grp[m_count % 4] = bus.i_byte_data;
        m_count++;
        m_rdy = cyc + 2;
        if (m_count % 4 == 0) begin
          word  = {grp[3], grp[2], grp[1], grp[0]};
          m_rdy = cyc + 3;
          if (word == 32'hFFFF_FFFF) begin
            m_rdy = INF; m_done = cyc + 3; m_busy_until = cyc + 3;
          end else if (m_count == 64) begin
            m_rdy = INF; m_ovf = cyc + 3; m_busy_until = cyc + 3;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output longint acc);
    bit got;
    got = 0;
    acc = -1;
    bus.i_byte_valid = 1'b0;
    repeat (gap) step();
    bus.i_byte_valid = 1'b1;
    bus.i_byte_data  = b;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.o_byte_ready) begin
        got = 1;
        acc = cyc;
      end
      step();
    end
    bus.i_byte_valid = 1'b0;
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  initial begin
    longint acc;
    logic [7:0] vec1 [8];
    logic [7:0] bp [16];
    vec1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte_data = 8'h00;
    settle(3);
    chk("reset_ready", 32'(bus.o_byte_ready), 32'd0);
    chk("reset_we",    32'(bus.o_write_enable), 32'd0);
    chk("reset_count", bus.o_byte_count, 32'd0);
    rst_n = 1'b1;
    settle(2);

    // basic load ending in HALT
    wlog.delete();
    pulse_start();
    foreach (vec1[i]) send_byte(vec1[i], 0, acc);
    settle(3);
    chk("t1_nwrites", 32'(wlog.size()), 32'd8);
    foreach (vec1[i]) begin
      if (i < wlog.size()) begin
        chk("t1_addr", wlog[i].addr, 32'(i));
        chk("t1_data", 32'(wlog[i].data), 32'(vec1[i]));
      end
    end
    chk("t1_done",  32'(bus.o_done), 32'd1);
    chk("t1_ovf",   32'(bus.o_overflow), 32'd0);
    chk("t1_count", bus.o_byte_count, 32'd8);

    // restart from DONE, start pulse while receiving is ignored
    pulse_start();
    chk("t5_done_clr", 32'(bus.o_done), 32'd0);
    chk("t5_count0",   bus.o_byte_count, 32'd0);
    send_byte(8'h11, 0, acc);
    bus.i_start = 1'b1;
    send_byte(8'h22, 1, acc);
    bus.i_start = 1'b0;
    settle(1);
    chk("t5_count2", bus.o_byte_count, 32'd2);
    send_byte(8'h33, 0, acc);
    send_byte(8'h44, 0, acc);
    for (int i = 0; i < 4; i++) send_byte(8'hFF, 0, acc);
    settle(3);
    chk("t5_done", 32'(bus.o_done), 32'd1);

    // non-HALT word: ready comes back three cycles after the boundary byte
    wlog.delete();
    pulse_start();
    send_byte(8'h13, 0, acc);
    send_byte(8'h00, 0, acc);
    send_byte(8'h00, 0, acc);
    send_byte(8'h00, 0, acc);
    @(negedge clk);
    chk("t6_rdy_n1", 32'(bus.o_byte_ready), 32'd0);
    step();
    @(negedge clk);
    chk("t6_rdy_n2", 32'(bus.o_byte_ready), 32'd0);
    step();
    @(negedge clk);
    chk("t6_rdy_n3", 32'(bus.o_byte_ready), 32'd1);
    chk("t6_cyc",    32'(cyc - acc), 32'd3);
    step();
    chk("t6_data0", 32'(wlog[0].data), 32'h13);
    chk("t6_data3", 32'(wlog[3].data), 32'h00);
    for (int i = 0; i < 4; i++) send_byte(8'hFF, 0, acc);
    settle(3);

    // overflow: FFs straddling a word boundary are not a HALT
    wlog.delete();
    pulse_start();
    send_byte(8'h00, 0, acc);
    for (int i = 0; i < 4; i++) send_byte(8'hFF, 0, acc);
    for (int i = 0; i < 59; i++) send_byte(8'h00, 0, acc);
    settle(3);
    bus.i_byte_valid = 1'b1;
    settle(5);
    bus.i_byte_valid = 1'b0;
    chk("t2_nwrites", 32'(wlog.size()), 32'd64);
    chk("t2_last",    wlog[wlog.size()-1].addr, 32'd63);
    chk("t2_ovf",     32'(bus.o_overflow), 32'd1);
    chk("t2_done",    32'(bus.o_done), 32'd0);
    chk("t2_ready",   32'(bus.o_byte_ready), 32'd0);
    chk("t2_count",   bus.o_byte_count, 32'd64);

    // backpressure with random gaps
    for (int i = 0; i < 12; i++) bp[i] = 8'(i * 7 + 1);
    for (int i = 12; i < 16; i++) bp[i] = 8'hFF;
    wlog.delete();
    pulse_start();
    foreach (bp[i]) send_byte(bp[i], int'($urandom_range(0, 3)), acc);
    settle(3);
    chk("t3_nwrites", 32'(wlog.size()), 32'd16);
    foreach (bp[i]) begin
      if (i < wlog.size()) begin
        chk("t3_addr", wlog[i].addr, 32'(i));
        chk("t3_data", 32'(wlog[i].data), 32'(bp[i]));
      end
    end
    chk("t3_done", 32'(bus.o_done), 32'd1);

    // asynchronous reset while the third byte is being written
    pulse_start();
    send_byte(8'hA1, 0, acc);
    send_byte(8'hA2, 0, acc);
    send_byte(8'hA3, 0, acc);
    rst_n = 1'b0;
    #1;
    chk("t4_we",    32'(bus.o_write_enable), 32'd0);
    chk("t4_busy",  32'(bus.o_busy), 32'd0);
    chk("t4_count", bus.o_byte_count, 32'd0);
    settle(2);
    rst_n = 1'b1;
    settle(1);
    wlog.delete();
    pulse_start();
    foreach (vec1[i]) send_byte(vec1[i], 0, acc);
    settle(3);
    chk("t4_first", wlog[0].addr, 32'd0);
    chk("t4_done",  32'(bus.o_done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
